// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions: loader FSM state encoding and the
// instruction word width used by the loader and the instruction memory.
package kgp_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready handshake feeding the program loader.
//   in_valid : byte available on in_data (source -> loader)
//   in_data  : stream byte (source -> loader)
//   in_ready : loader accepts a byte this cycle (loader -> source)
// A byte transfers on a rising edge where in_valid && in_ready.
interface imem_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/byte_packer.sv
// Assembles big-endian instruction words from a byte stream.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : drop any partial word and restart at byte 0
//   shift     : accept byte_in this cycle
//   byte_in   : stream byte; the first byte of a word lands in [31:24]
//   word_next : word including byte_in (complete when word_full is high)
//   word_full : high in the cycle the 4th byte of a word is shifted in
module byte_packer
  import kgp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word_next,
  output logic               word_full
);

  logic [1:0]         cnt_q;
  logic [INSTR_W-1:0] word_q;

  assign word_next = {word_q[INSTR_W-9:0], byte_in};
  assign word_full = shift && (cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (shift) begin
      cnt_q  <= cnt_q + 2'd1;
      word_q <= word_next;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader for the KGP-RISC instruction memory. Reads a 2-byte
// big-endian word count followed by big-endian instruction words, writes
// them to consecutive word addresses from 0, and holds the core in reset
// until a complete, legal image is in memory.
//   clk, rst     : clock, synchronous active-high reset
//   start        : pulse; begins or restarts a load from any state
//   stream       : byte-stream handshake (slave side)
//   imem_we      : one-cycle write strobe per word
//   imem_addr    : word address of the write
//   imem_wdata   : instruction word
//   cpu_rst      : core reset, released only while the image is complete
//   busy         : load in progress
//   done         : image loaded, core running
//   error        : header word count exceeds the memory depth
//   words_loaded : words written in the current load
module imem_loader
  import kgp_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  imem_loader_if.slave       stream,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [LEN_W-1:0]   words_loaded
);

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

  state_t             state_q, state_d;
  logic [7:0]         len_hi_q;
  logic [LEN_W-1:0]   len_q;
  logic [15:0]        hdr;
  logic               accept;
  logic               shift;
  logic               word_full;
  logic [INSTR_W-1:0] packed_word;

  assign stream.in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                           (state_q == S_DATA);
  assign accept = stream.in_valid && stream.in_ready;
  assign shift  = (state_q == S_DATA) && accept;
  assign hdr    = {len_hi_q, stream.in_data};

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start),
    .shift     (shift),
    .byte_in   (stream.in_data),
    .word_next (packed_word),
    .word_full (word_full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LEN_HI;
      S_LEN_HI: if (accept) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (hdr == 16'd0)             state_d = S_DONE;
          else if ({16'd0, hdr} > DEPTH) state_d = S_ERR;
          else                           state_d = S_DATA;
        end
      end
      S_DATA:   if (word_full) state_d = S_WRITE;
      S_WRITE:  state_d = ((words_loaded + LEN_W'(1)) == len_q) ? S_DONE : S_DATA;
      S_DONE,
      S_ERR:    if (start) state_d = S_LEN_HI;
      default:  state_d = S_IDLE;
    endcase
    // start aborts whatever is in flight
    if (start) state_d = S_LEN_HI;
  end

  // Status outputs are registered from state_d so they change together
  // with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_hi_q     <= '0;
      len_q        <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state_q <= state_d;
      imem_we <= (state_d == S_WRITE);
      cpu_rst <= (state_d != S_DONE);
      busy    <= state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE};
      done    <= (state_d == S_DONE);
      error   <= (state_d == S_ERR);

      if ((state_q == S_LEN_HI) && accept) len_hi_q <= stream.in_data;
      if ((state_q == S_LEN_LO) && accept) len_q <= LEN_W'(hdr);
      if (word_full) imem_wdata <= packed_word;

      if (start) begin
        imem_addr    <= '0;
        words_loaded <= '0;
      end else if (state_q == S_WRITE) begin
        words_loaded <= words_loaded + LEN_W'(1);
        // the final write keeps its address so a full-depth image never wraps
        if (state_d == S_DATA) imem_addr <= imem_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one default-size instance (A) and one
// ADDR_W=4 instance (B) for the depth boundaries.
module tb_imem_loader;
  import kgp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic a_start, b_start;

  imem_loader_if a_if ();
  imem_loader_if b_if ();

  logic        a_we, a_cpu_rst, a_busy, a_done, a_error;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic [15:0] a_words;

  logic        b_we, b_cpu_rst, b_busy, b_done, b_error;
  logic [3:0]  b_addr;
  logic [31:0] b_wdata;
  logic [15:0] b_words;

  int n_cmp  = 0;
  int n_fail = 0;

  int unsigned qa_addr[$];
  logic [31:0] qa_data[$];
  int unsigned qb_addr[$];
  logic [31:0] qb_data[$];

  imem_loader #(.ADDR_W(10), .LEN_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .stream(a_if),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .cpu_rst(a_cpu_rst), .busy(a_busy), .done(a_done), .error(a_error),
    .words_loaded(a_words)
  );

  imem_loader #(.ADDR_W(4), .LEN_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .stream(b_if),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .cpu_rst(b_cpu_rst), .busy(b_busy), .done(b_done), .error(b_error),
    .words_loaded(b_words)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_we === 1'b1) begin
      qa_addr.push_back(int'(a_addr));
      qa_data.push_back(a_wdata);
    end
    if (b_we === 1'b1) begin
      qb_addr.push_back(int'(b_addr));
      qb_data.push_back(b_wdata);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input bit sel);
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  // Offer one byte and hold it until the loader takes it.
  task automatic send(input bit sel, input logic [7:0] b);
    int n = 0;
    logic rdy;
    if (sel) begin b_if.in_valid = 1'b1; b_if.in_data = b; end
    else     begin a_if.in_valid = 1'b1; a_if.in_data = b; end
    @(negedge clk);
    rdy = sel ? b_if.in_ready : a_if.in_ready;
    while (rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      rdy = sel ? b_if.in_ready : a_if.in_ready;
      n++;
    end
    check("ready_wait", (n < 50), 1);
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    b_if.in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] img [0:9];
    img = '{8'h00, 8'h02, 8'h20, 8'h21, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04};

    rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_data = '0;
    b_if.in_valid = 1'b0; b_if.in_data = '0;
    repeat (2) @(posedge clk); #1;

    // reset values
    check("rst_in_ready", a_if.in_ready, 0);
    check("rst_we", a_we, 0);
    check("rst_addr", a_addr, 0);
    check("rst_wdata", a_wdata, 0);
    check("rst_cpu_rst", a_cpu_rst, 1);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_error", a_error, 0);
    check("rst_words", a_words, 0);
    check("rst_b_cpu_rst", b_cpu_rst, 1);
    rst = 1'b0;

    // two-word image, valid held high
    pulse(0);
    check("t1_busy", a_busy, 1);
    check("t1_ready", a_if.in_ready, 1);
    for (int i = 0; i < 10; i++) send(0, img[i]);
    @(posedge clk); #1;
    check("t1_done", a_done, 1);
    check("t1_cpu_rst", a_cpu_rst, 0);
    check("t1_words", a_words, 2);
    check("t1_busy_end", a_busy, 0);
    check("t1_ready_end", a_if.in_ready, 0);
    check("t1_nwrites", qa_addr.size(), 2);
    check("t1_addr0", qa_addr[0], 0);
    check("t1_data0", qa_data[0], 32'h20210005);
    check("t1_addr1", qa_addr[1], 1);
    check("t1_data1", qa_data[1], 32'h8C220004);
    a_if.in_valid = 1'b1; a_if.in_data = 8'hFF;
    repeat (3) @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    check("t1_extra_done", a_done, 1);
    check("t1_extra_nwrites", qa_addr.size(), 2);

    // empty image
    qa_addr.delete(); qa_data.delete();
    pulse(0);
    check("t2_cpu_rst_restart", a_cpu_rst, 1);
    check("t2_done_cleared", a_done, 0);
    send(0, 8'h00);
    send(0, 8'h00);
    check("t2_done", a_done, 1);
    check("t2_cpu_rst", a_cpu_rst, 0);
    check("t2_nwrites", qa_addr.size(), 0);
    check("t2_words", a_words, 0);

    // ADDR_W=4: length 17 is illegal
    pulse(1);
    send(1, 8'h00);
    send(1, 8'h11);
    check("t3_error", b_error, 1);
    check("t3_cpu_rst", b_cpu_rst, 1);
    check("t3_ready", b_if.in_ready, 0);
    check("t3_busy", b_busy, 0);
    pulse(1);
    check("t3_error_clr", b_error, 0);
    check("t3_busy_restart", b_busy, 1);
    // length 16 fills the memory exactly
    send(1, 8'h00);
    send(1, 8'h10);
    for (int i = 0; i < 64; i++) send(1, 8'(i));
    @(posedge clk); #1;
    check("t3_done", b_done, 1);
    check("t3_words", b_words, 16);
    check("t3_addr_nowrap", b_addr, 15);
    check("t3_nwrites", qb_addr.size(), 16);
    check("t3_first_addr", qb_addr[0], 0);
    check("t3_first_data", qb_data[0], 32'h00010203);
    check("t3_last_addr", qb_addr[15], 15);
    check("t3_last_data", qb_data[15], 32'h3C3D3E3F);

    // gaps in in_valid during DATA
    qa_addr.delete(); qa_data.delete();
    pulse(0);
    send(0, img[0]);
    send(0, img[1]);
    for (int i = 0; i < 8; i++) begin
      send(0, img[2+i]);
      if (i % 4 != 3) begin
        repeat ((i % 3) + 1) begin
          @(negedge clk);
          check("t4_ready_stall", a_if.in_ready, 1);
        end
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    check("t4_done", a_done, 1);
    check("t4_nwrites", qa_addr.size(), 2);
    check("t4_addr0", qa_addr[0], 0);
    check("t4_data0", qa_data[0], 32'h20210005);
    check("t4_addr1", qa_addr[1], 1);
    check("t4_data1", qa_data[1], 32'h8C220004);

    // restart with a partial second word in flight
    pulse(0);
    for (int i = 0; i < 8; i++) send(0, img[i]);
    check("t5_words_before", a_words, 1);
    pulse(0);
    check("t5_words_clr", a_words, 0);
    check("t5_addr_clr", a_addr, 0);
    check("t5_ready", a_if.in_ready, 1);
    qa_addr.delete(); qa_data.delete();
    send(0, 8'h00);
    send(0, 8'h01);
    send(0, 8'hAA);
    send(0, 8'hBB);
    send(0, 8'hCC);
    send(0, 8'hDD);
    @(posedge clk); #1;
    check("t5_done", a_done, 1);
    check("t5_words", a_words, 1);
    check("t5_nwrites", qa_addr.size(), 1);
    check("t5_addr0", qa_addr[0], 0);
    check("t5_data0", qa_data[0], 32'hAABBCCDD);

    // reset during WRITE
    pulse(0);
    send(0, 8'h00);
    send(0, 8'h01);
    send(0, 8'h11);
    send(0, 8'h22);
    send(0, 8'h33);
    send(0, 8'h44);
    check("t6_we", a_we, 1);
    check("t6_wdata", a_wdata, 32'h11223344);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_we_rst", a_we, 0);
    check("t6_cpu_rst", a_cpu_rst, 1);
    check("t6_wdata_rst", a_wdata, 0);
    check("t6_busy", a_busy, 0);
    check("t6_done", a_done, 0);
    check("t6_words", a_words, 0);
    check("t6_ready", a_if.in_ready, 0);
    // start is ignored while rst is high
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_start_in_rst_ready", a_if.in_ready, 0);
    check("t6_start_in_rst_busy", a_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
